// File: rtl/serial_sub_cmp_if.sv
// Handshake and operand/result bundle for serial_sub_cmp.
// With SUBCMP_ADD_MODE_EN defined the bundle also carries op_add.
interface serial_sub_cmp_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
`ifdef SUBCMP_ADD_MODE_EN
    logic             op_add;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic             isNotEqual;
    logic             isLessThan;
    logic             isLessThanU;

`ifdef SUBCMP_ADD_MODE_EN
    modport master (
        output in_valid, dataA, dataB, op_add, out_ready,
        input  in_ready, out_valid, result, overflow, isNotEqual, isLessThan, isLessThanU
    );
    modport slave (
        input  in_valid, dataA, dataB, op_add, out_ready,
        output in_ready, out_valid, result, overflow, isNotEqual, isLessThan, isLessThanU
    );
`else
    modport master (
        output in_valid, dataA, dataB, out_ready,
        input  in_ready, out_valid, result, overflow, isNotEqual, isLessThan, isLessThanU
    );
    modport slave (
        input  in_valid, dataA, dataB, out_ready,
        output in_ready, out_valid, result, overflow, isNotEqual, isLessThan, isLessThanU
    );
`endif
endinterface

// File: rtl/serial_sub_cmp.sv
// Multi-cycle subtract/compare unit: processes CHUNK bits of A-B per clock and
// reports result, signed overflow, not-equal, signed and unsigned less-than.
// Optional feature macro: SUBCMP_ADD_MODE_EN (adds op_add, selecting A+B).
module serial_sub_cmp #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input logic            clock,
    input logic            reset,
    serial_sub_cmp_if.slave bus
);
    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

    if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("serial_sub_cmp: illegal WIDTH/CHUNK combination");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] bop_q;
    logic [WIDTH-1:0] result_q;
    logic             carry;
    logic             is_add;
    logic             overflow_q;
    logic             neq_q;
    logic             lt_q;
    logic             ltu_q;

    logic             in_ready;
    logic             accept;
    logic             last;
    logic             add_sel;
    logic [31:0]      shift;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] result_next;
    logic             ovf_next;

`ifdef SUBCMP_ADD_MODE_EN
    assign add_sel = bus.op_add;
`else
    assign add_sel = 1'b0;
`endif

    assign last   = (cnt == CNT_W'(N - 1));
    assign accept = bus.in_valid & in_ready;

    // State register.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of process evaluation order.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_next    = state;
        in_ready      = (state == IDLE) || ((state == DONE) && bus.out_ready);
        bus.in_ready  = in_ready;
        bus.out_valid = (state == DONE);
        case (state)
            IDLE: if (bus.in_valid) state_next = BUSY;
            BUSY: if (last) state_next = DONE;
            DONE: begin
                if (bus.in_valid && bus.out_ready) state_next = BUSY;
                else if (bus.out_ready)            state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Current chunk adder; the result chunk is merged into the full word so
    // isNotEqual sees the final chunk on the same edge it is written.
    always_comb begin
        shift       = 32'(cnt) * CHUNK;
        a_chunk     = CHUNK'(a_q >> shift);
        b_chunk     = CHUNK'(bop_q >> shift);
        chunk_sum   = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
        result_next = (result_q & ~(CHUNK_MASK << shift))
                    | (WIDTH'(chunk_sum[CHUNK-1:0]) << shift);
        // Carry into the MSB is recovered from the MSB sum bit and its operands.
        ovf_next    = (a_q[WIDTH-1] ^ bop_q[WIDTH-1] ^ chunk_sum[CHUNK-1]) ^ chunk_sum[CHUNK];
    end

    // Operand capture, chunk accumulation and final flag evaluation.
    always_ff @(posedge clock) begin
        if (reset) begin
            a_q        <= '0;
            bop_q      <= '0;
            result_q   <= '0;
            carry      <= 1'b0;
            is_add     <= 1'b0;
            cnt        <= '0;
            overflow_q <= 1'b0;
            neq_q      <= 1'b0;
            lt_q       <= 1'b0;
            ltu_q      <= 1'b0;
        end else if (accept) begin
            a_q    <= bus.dataA;
            bop_q  <= add_sel ? bus.dataB : ~bus.dataB;
            carry  <= ~add_sel;
            is_add <= add_sel;
            cnt    <= '0;
        end else if (state == BUSY) begin
            result_q <= result_next;
            carry    <= chunk_sum[CHUNK];
            cnt      <= cnt + CNT_W'(1);
            if (last) begin
                overflow_q <= ovf_next;
                neq_q      <= |result_next;
                lt_q       <= ~is_add & (ovf_next ^ chunk_sum[CHUNK-1]);
                ltu_q      <= ~is_add & ~chunk_sum[CHUNK];
            end
        end
    end

    assign bus.result      = result_q;
    assign bus.overflow    = overflow_q;
    assign bus.isNotEqual  = neq_q;
    assign bus.isLessThan  = lt_q;
    assign bus.isLessThanU = ltu_q;

endmodule
